// File: rtl/gpio_pkg.sv
// Shared GPIO constants: pin-count limit, flag bit position and default
// register addresses of the B/C/D port instances.
package gpio_pkg;

    localparam int unsigned GPIO_MAX_WIDTH = 8;
    localparam int unsigned GPIO_ADDR_W    = 6;
    localparam int unsigned GPIO_FLAG_BIT  = 0;

    // Register address set of one port instance
    typedef struct packed {
        logic [GPIO_ADDR_W-1:0] pin;
        logic [GPIO_ADDR_W-1:0] ddr;
        logic [GPIO_ADDR_W-1:0] port;
    } gpio_addr_t;

    localparam gpio_addr_t GPIO_B_ADDR = '{pin: 6'h03, ddr: 6'h04, port: 6'h05};
    localparam gpio_addr_t GPIO_C_ADDR = '{pin: 6'h06, ddr: 6'h07, port: 6'h08};
    localparam gpio_addr_t GPIO_D_ADDR = '{pin: 6'h09, ddr: 6'h0A, port: 6'h0B};

endpackage

// File: rtl/gpio_sync2.sv
// Parametrised-width two-flop synchroniser, synchronous active-high reset.
module gpio_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_port_gen.sv
// Parametrised GPIO port with override matrix and synchronised inputs.
// Optional pin-change interrupt unit enabled by GPIO_PORT_PCINT_EN.
module gpio_port_gen
    import gpio_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [GPIO_ADDR_W-1:0] PIN_ADDR  = GPIO_C_ADDR.pin,
    parameter logic [GPIO_ADDR_W-1:0] DDR_ADDR  = GPIO_C_ADDR.ddr,
    parameter logic [GPIO_ADDR_W-1:0] PORT_ADDR = GPIO_C_ADDR.port,
    parameter logic [GPIO_ADDR_W-1:0] MSK_ADDR  = 6'h0A,
    parameter logic [GPIO_ADDR_W-1:0] FLG_ADDR  = 6'h0B
) (
    input  logic                      cp2,
    input  logic                      ireset,
    input  logic [GPIO_ADDR_W-1:0]    IO_Addr,
    input  logic                      iore,
    input  logic                      iowe,
    input  logic [GPIO_MAX_WIDTH-1:0] dbus_in,
    output logic [GPIO_MAX_WIDTH-1:0] dbus_out,
    output logic                      out_en,
    input  logic [WIDTH-1:0]          pin_i,
    output logic [WIDTH-1:0]          di_o,
    output logic [WIDTH-1:0]          pu_o,
    output logic [WIDTH-1:0]          dd_o,
    output logic [WIDTH-1:0]          pv_o,
    output logic [WIDTH-1:0]          die_o,
    input  logic                      PUD,
    input  logic                      SLEEP,
    input  logic [WIDTH-1:0]          puoe,
    input  logic [WIDTH-1:0]          puov,
    input  logic [WIDTH-1:0]          ddoe,
    input  logic [WIDTH-1:0]          ddov,
    input  logic [WIDTH-1:0]          pvoe,
    input  logic [WIDTH-1:0]          pvov,
    input  logic [WIDTH-1:0]          dieoe,
    input  logic [WIDTH-1:0]          dieov,
    input  logic                      pcie,
    output logic                      pcint_irq
);

    logic [WIDTH-1:0]          ddr;
    logic [WIDTH-1:0]          port;
    logic [WIDTH-1:0]          wr_data;
    logic [WIDTH-1:0]          sync_in;
    logic                      wr_pin;
    logic                      wr_ddr;
    logic                      wr_port;
    logic                      rd_hit;
    logic [GPIO_MAX_WIDTH-1:0] rd_data;
    logic                      unused_bus;

    assign wr_data    = dbus_in[WIDTH-1:0];
    assign wr_pin     = iowe && (IO_Addr == PIN_ADDR);
    assign wr_ddr     = iowe && (IO_Addr == DDR_ADDR);
    assign wr_port    = iowe && (IO_Addr == PORT_ADDR);
    assign unused_bus = ^dbus_in;

    // Pad control: each override enable selects its override value per pin
    assign dd_o  = (ddoe & ddov) | (~ddoe & ddr);
    assign pv_o  = (pvoe & pvov) | (~pvoe & port);
    assign pu_o  = (puoe & puov) | (~puoe & ~ddr & port & {WIDTH{~PUD}});
    assign die_o = (dieoe & dieov) | (~dieoe & {WIDTH{~SLEEP}});

    // A disabled digital input presents 0 to the synchroniser
    assign sync_in = pin_i & die_o;

    gpio_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (cp2),
        .rst (ireset),
        .d   (sync_in),
        .q   (di_o)
    );

    // Writing PINx toggles PORTx bits that are written as 1
    always_ff @(posedge cp2) begin
        if (ireset) begin
            ddr  <= '0;
            port <= '0;
        end else begin
            if (wr_ddr) begin
                ddr <= wr_data;
            end
            if (wr_port) begin
                port <= wr_data;
            end else if (wr_pin) begin
                port <= port ^ wr_data;
            end
        end
    end

`ifdef GPIO_PORT_PCINT_EN
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] prev;
    logic             flag;
    logic             wr_msk;
    logic             wr_flg;
    logic             pc_hit;

    assign wr_msk = iowe && (IO_Addr == MSK_ADDR);
    assign wr_flg = iowe && (IO_Addr == FLG_ADDR);
    assign pc_hit = |((di_o ^ prev) & msk);

    // prev follows di_o unconditionally so a new mask bit sees no stale edge
    always_ff @(posedge cp2) begin
        if (ireset) begin
            msk  <= '0;
            prev <= '0;
            flag <= 1'b0;
        end else begin
            prev <= di_o;
            if (wr_msk) begin
                msk <= wr_data;
            end
            if (pc_hit) begin
                flag <= 1'b1;
            end else if (wr_flg && dbus_in[GPIO_FLAG_BIT]) begin
                flag <= 1'b0;
            end
        end
    end

    assign pcint_irq = flag & pcie;
`else
    logic unused_pcie;

    assign unused_pcie = pcie;
    assign pcint_irq   = 1'b0;
`endif

    // Register read mux; unimplemented addresses return 0 with out_en low
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (IO_Addr == PIN_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = GPIO_MAX_WIDTH'(di_o);
        end else if (IO_Addr == DDR_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = GPIO_MAX_WIDTH'(ddr);
        end else if (IO_Addr == PORT_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = GPIO_MAX_WIDTH'(port);
        end
`ifdef GPIO_PORT_PCINT_EN
        else if (IO_Addr == MSK_ADDR) begin
            rd_hit  = 1'b1;
            rd_data = GPIO_MAX_WIDTH'(msk);
        end else if (IO_Addr == FLG_ADDR) begin
            rd_hit                 = 1'b1;
            rd_data[GPIO_FLAG_BIT] = flag;
        end
`endif
    end

    assign out_en   = iore & rd_hit;
    assign dbus_out = out_en ? rd_data : '0;

endmodule

// File: tb/tb_gpio_port_gen.sv
// Self-checking bench for gpio_port_gen (WIDTH=7): directed cases plus
// randomized traffic against a cycle-level reference model.
module tb_gpio_port_gen;

    localparam int unsigned W = 7;
`ifdef GPIO_PORT_PCINT_EN
    localparam bit PCINT = 1'b1;
`else
    localparam bit PCINT = 1'b0;
`endif

    logic         cp2 = 1'b0;
    logic         ireset;
    logic [5:0]   IO_Addr;
    logic         iore, iowe;
    logic [7:0]   dbus_in, dbus_out;
    logic         out_en;
    logic [W-1:0] pin_i, di_o, pu_o, dd_o, pv_o, die_o;
    logic         PUD, SLEEP;
    logic [W-1:0] puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov;
    logic         pcie, pcint_irq;

    gpio_port_gen #(.WIDTH(W)) dut (
        .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
        .pin_i(pin_i), .di_o(di_o), .pu_o(pu_o), .dd_o(dd_o), .pv_o(pv_o), .die_o(die_o),
        .PUD(PUD), .SLEEP(SLEEP),
        .puoe(puoe), .puov(puov), .ddoe(ddoe), .ddov(ddov),
        .pvoe(pvoe), .pvov(pvov), .dieoe(dieoe), .dieov(dieov),
        .pcie(pcie), .pcint_irq(pcint_irq)
    );

    always #5 cp2 = ~cp2;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state; hist[k] is the gated pad value sampled k+1 edges ago
    logic [W-1:0] m_ddr, m_port, m_msk;
    logic         m_flag;
    logic [W-1:0] hist [3];

    function automatic logic [W-1:0] pick(input logic [W-1:0] oe, input logic [W-1:0] ov,
                                          input logic [W-1:0] dflt);
        logic [W-1:0] r;
        for (int n = 0; n < W; n++) r[n] = oe[n] ? ov[n] : dflt[n];
        return r;
    endfunction

    function automatic logic [W-1:0] e_pu();
        logic [W-1:0] d;
        for (int n = 0; n < W; n++) d[n] = (!m_ddr[n] && m_port[n] && !PUD);
        return pick(puoe, puov, d);
    endfunction

    function automatic logic [W-1:0] e_die();
        return pick(dieoe, dieov, SLEEP ? '0 : '1);
    endfunction

    function automatic logic [8:0] e_read();
        logic [7:0] d;
        logic       hit;
        hit = 1'b1;
        d   = 8'h00;
        case (IO_Addr)
            6'h06: d = {1'b0, hist[1]};
            6'h07: d = {1'b0, m_ddr};
            6'h08: d = {1'b0, m_port};
            6'h0A: begin hit = PCINT; d = PCINT ? {1'b0, m_msk} : 8'h00; end
            6'h0B: begin hit = PCINT; d = {7'h00, PCINT & m_flag}; end
            default: hit = 1'b0;
        endcase
        if (!(iore && hit)) return 9'h000;
        return {1'b1, d};
    endfunction

    task automatic check_all(input string ph);
        logic [8:0] rd;
        rd = e_read();
        check_eq({ph, "_dd"},   32'(dd_o),  32'(pick(ddoe, ddov, m_ddr)));
        check_eq({ph, "_pv"},   32'(pv_o),  32'(pick(pvoe, pvov, m_port)));
        check_eq({ph, "_pu"},   32'(pu_o),  32'(e_pu()));
        check_eq({ph, "_die"},  32'(die_o), 32'(e_die()));
        check_eq({ph, "_di"},   32'(di_o),  32'(hist[1]));
        check_eq({ph, "_irq"},  32'(pcint_irq), 32'(m_flag & pcie));
        check_eq({ph, "_oen"},  32'(out_en),   32'(rd[8]));
        check_eq({ph, "_dout"}, 32'(dbus_out), 32'(rd[7:0]));
    endtask

    // Check current outputs, then advance DUT and model by one clock edge
    task automatic tick();
        logic [W-1:0] nddr, nport, nmsk, samp, wd;
        logic         nflag, chg;
        #1;
        check_all("cyc");
        wd    = dbus_in[W-1:0];
        samp  = pin_i & e_die();
        nddr  = m_ddr;
        nport = m_port;
        nmsk  = m_msk;
        nflag = m_flag;
        chg   = PCINT && (((hist[1] ^ hist[2]) & m_msk) != '0);
        if (iowe) begin
            if (IO_Addr == 6'h07) nddr = wd;
            if (IO_Addr == 6'h08) nport = wd;
            if (IO_Addr == 6'h06) nport = m_port ^ wd;
            if (PCINT && IO_Addr == 6'h0A) nmsk = wd;
            if (PCINT && IO_Addr == 6'h0B && dbus_in[0]) nflag = 1'b0;
        end
        if (chg) nflag = 1'b1;
        @(posedge cp2);
        #1;
        if (ireset) begin
            m_ddr = '0; m_port = '0; m_msk = '0; m_flag = 1'b0;
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            m_ddr = nddr; m_port = nport; m_msk = nmsk; m_flag = nflag;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = samp;
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        iowe = 1'b1; IO_Addr = a; dbus_in = d;
        tick();
        iowe = 1'b0;
    endtask

    initial begin
        ireset = 1'b1; IO_Addr = '0; iore = 1'b0; iowe = 1'b0; dbus_in = '0;
        pin_i = '0; PUD = 1'b0; SLEEP = 1'b0; pcie = 1'b0;
        puoe = '0; puov = '0; ddoe = '0; ddov = '0; pvoe = '0; pvov = '0; dieoe = '0; dieov = '0;
        m_ddr = '0; m_port = '0; m_msk = '0; m_flag = 1'b0;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        @(posedge cp2);
        #1;
        tick();
        ireset = 1'b0;
        #1;
        check_eq("rst_dd", 32'(dd_o), 0);
        check_eq("rst_pv", 32'(pv_o), 0);
        check_eq("rst_pu", 32'(pu_o), 0);
        check_eq("rst_die", 32'(die_o), 32'h7F);
        check_eq("rst_di", 32'(di_o), 0);
        check_eq("rst_irq", 32'(pcint_irq), 0);

        // Pull-up derivation and global disable
        bus_write(6'h07, 8'h00);
        bus_write(6'h08, 8'h7F);
        #1;
        check_eq("pu_on", 32'(pu_o), 32'h7F);
        check_eq("dd_in", 32'(dd_o), 0);
        PUD = 1'b1;
        #1;
        check_eq("pu_pud", 32'(pu_o), 0);
        PUD = 1'b0;

        // PIN write toggles PORT; upper bus bit reads back as zero
        bus_write(6'h07, 8'h7F);
        bus_write(6'h08, 8'h00);
        bus_write(6'h06, 8'h0F);
        #1;
        check_eq("pin_tog1", 32'(pv_o), 32'h0F);
        bus_write(6'h06, 8'h0F);
        #1;
        check_eq("pin_tog2", 32'(pv_o), 0);
        bus_write(6'h08, 8'hFF);
        iore = 1'b1; IO_Addr = 6'h08;
        #1;
        check_eq("port_rd", 32'(dbus_out), 32'h7F);
        // Same-cycle write and read returns the old value
        iowe = 1'b1; dbus_in = 8'h11;
        #1;
        check_eq("rw_old", 32'(dbus_out), 32'h7F);
        tick();
        iowe = 1'b0;
        #1;
        check_eq("rw_new", 32'(dbus_out), 32'h11);
        iore = 1'b0;

        // Overrides
        ddoe = 7'h7E; ddov = 7'h00; pvoe = 7'h7F; pvov = 7'h55;
        #1;
        check_eq("ovr_dd", 32'(dd_o), 32'h01);
        check_eq("ovr_pv", 32'(pv_o), 32'h55);
        tick();
        ddoe = '0; pvoe = '0;

        // Input latency and sleep gating
        pin_i = 7'h04;
        tick();
        #1;
        check_eq("di_lat1", 32'(di_o), 0);
        tick();
        iore = 1'b1; IO_Addr = 6'h06;
        #1;
        check_eq("pin_rd", 32'(dbus_out), 32'h04);
        iore = 1'b0;
        SLEEP = 1'b1;
        tick(); tick();
        #1;
        check_eq("di_sleep", 32'(di_o), 0);
        SLEEP = 1'b0;
        tick(); tick();

        // Pin-change interrupt, W1C collision and clear
        bus_write(6'h0A, 8'h04);
        pcie = 1'b1;
        pin_i = 7'h00;
        tick(); tick();
        #1;
        check_eq("pc_early", 32'(pcint_irq), 0);
        tick();
        #1;
        check_eq("pc_set", 32'(pcint_irq), 32'(PCINT));
        pin_i = 7'h04;
        tick(); tick();
        bus_write(6'h0B, 8'h01);
        #1;
        check_eq("pc_setwins", 32'(pcint_irq), 32'(PCINT));
        bus_write(6'h0B, 8'h01);
        #1;
        check_eq("pc_clr", 32'(pcint_irq), 0);
        iore = 1'b1; IO_Addr = 6'h0A;
        #1;
        check_eq("msk_oen", 32'(out_en), 32'(PCINT));
        iore = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [5:0] alist [6];
            alist[0] = 6'h06; alist[1] = 6'h07; alist[2] = 6'h08;
            alist[3] = 6'h0A; alist[4] = 6'h0B; alist[5] = 6'($urandom);
            ireset  = ($urandom_range(0, 63) == 0);
            iowe    = ($urandom_range(0, 2) == 0);
            iore    = ($urandom_range(0, 1) == 0);
            IO_Addr = alist[$urandom_range(0, 5)];
            dbus_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pin_i = W'($urandom);
            if ($urandom_range(0, 15) == 0) PUD = ~PUD;
            if ($urandom_range(0, 15) == 0) SLEEP = ~SLEEP;
            pcie  = ($urandom_range(0, 3) != 0);
            puoe  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            ddoe  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            pvoe  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            dieoe = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            puov  = W'($urandom); ddov = W'($urandom);
            pvov  = W'($urandom); dieov = W'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_port_gen.md
# gpio_port_gen

Parametrised general-purpose I/O port for the 8-bit MCU core, the generic successor to the fixed per-port blocks (Port B/C/D). It supports any port width up to 8 with relocatable IO addresses and a per-pin alternate-function override matrix. It adds two-flop input synchronisation and an optional pin-change interrupt unit (mask register, flag, request). It sits on the core IO bus beside the other peripherals and drives the pad-control signals.

## Interface
- WIDTH, 8, number of pins (1..8); bus bits at or above WIDTH read 0 and ignore writes
- PIN_ADDR, 6'h06, PINx address (read: synchronised input; write: toggle PORTx)
- DDR_ADDR, 6'h07, DDRx address
- PORT_ADDR, 6'h08, PORTx address
- MSK_ADDR, 6'h0A, pin-change mask address (PCINT build only)
- FLG_ADDR, 6'h0B, pin-change flag address, bit 0 only (PCINT build only)

Ports:
- cp2  in  1  core clock; all state changes on its rising edge
- ireset  in  1  synchronous, active-high reset
- IO_Addr  in  6  IO address
- iore / iowe  in  1  IO read / write strobe
- dbus_in  in  8  write data
- dbus_out  out  8  read data, valid while out_en=1
- out_en  out  1  iore=1 and IO_Addr matches an implemented register
- pin_i  in  WIDTH  raw pad inputs
- di_o  out  WIDTH  synchronised digital input, routed to other peripherals
- pu_o / dd_o / pv_o / die_o  out  WIDTH  pull-up, direction, port value, digital-input enable
- PUD, SLEEP  in  1  global pull-up disable; sleep
- puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov  in  WIDTH  per-pin override enables and values
- pcie  in  1  pin-change interrupt enable for this port
- pcint_irq  out  1  pin-change interrupt request

## Operation
- Pad-control outputs are combinational, per pin n:
  - dd = ddoe ? ddov : DDR[n]
  - pv = pvoe ? pvov : PORT[n]
  - pu = puoe ? puov : (~DDR[n] & PORT[n] & ~PUD)
  - die = dieoe ? dieov : ~SLEEP
- Input path: pin_i & die_o feeds the gpio_sync2 two-flop synchroniser; its output is di_o, and di_o is the value read at PIN_ADDR.
- Writes occur when iowe=1 at the clock edge:
  - DDR_ADDR, PORT_ADDR, MSK_ADDR load dbus_in[WIDTH-1:0].
  - PIN_ADDR XORs dbus_in into PORT; a 0 bit leaves PORT unchanged.
  - FLG_ADDR: writing 1 to bit 0 clears the flag (write-one-to-clear).
- Reads are combinational from the register or di_o. Unmatched addresses give out_en=0 and dbus_out=0.
- Pin change:
  - A previous-sample register prev tracks di_o every cycle, regardless of the mask.
  - The flag sets when (di_o ^ prev) & MSK is nonzero.
  - pcint_irq = flag & pcie.

## Timing
- Reset values: DDR, PORT, MSK, flag, synchroniser flops and prev are all 0. With overrides inactive this gives dd_o=0, pv_o=0, pu_o=0, die_o=~SLEEP, di_o=0, pcint_irq=0.
- Reset asserted mid-operation clears all state on the next edge; a pending flag is lost.
- Register writes are visible on outputs and reads in the cycle after the write edge.
- Pin to di_o/PIN read: 2 cycles. Pin to flag set: 3 cycles. Flag to pcint_irq: combinational.
- A flag set and a W1C clear in the same cycle: set wins.
- Setting a MSK bit never raises a spurious flag, because prev already equals di_o.
- die_o=0 forces the synchroniser input to 0. Disabling die on a high pin therefore produces a 1->0 change that sets the flag if that pin is masked.
- Write and read in the same cycle at the same address: the read returns the old value.

## Configuration
- GPIO_PORT_PCINT_EN defined: MSK, flag, prev and pcint_irq are implemented as described.
- Undefined:
  - No MSK, flag or prev logic is built.
  - MSK_ADDR and FLG_ADDR are unimplemented: out_en=0 on read, writes are ignored.
  - pcint_irq is tied to 0.
  - The pcie input is unused but the port remains.

## Structure
- Shared package gpio_pkg holds:
  - default addresses for the B/C/D instances
  - GPIO_MAX_WIDTH = 8
  - the flag bit index constant
- Sub-module gpio_sync2: parametrised-width two-flop synchroniser with synchronous active-high reset, also used by other input peripherals.

## Test plan
- Reset, then WIDTH=7: write DDR=7'h00, PORT=7'h7F, PUD=0 -> pu_o=7'h7F, dd_o=0; set PUD=1 -> pu_o=0.
- DDR=7'h7F, PORT=7'h00, write PIN=7'h0F -> pv_o=7'h0F the next cycle; write PIN=7'h0F again -> pv_o=0; read PORT_ADDR at bit 7 -> 0.
- ddoe=7'h7E, ddov=0, DDR=7'h7F -> dd_o=7'h01; pvoe=7'h7F, pvov=7'h55 -> pv_o=7'h55 regardless of PORT.
- pin_i 0->7'h04 with SLEEP=0 -> PIN read returns 7'h04 two cycles later; SLEEP=1, dieoe=0 -> di_o goes to 0 after 2 cycles.
- PCINT build: MSK=7'h04, pcie=1, toggle pin_i[2] -> pcint_irq=1 on the 3rd edge. Write FLG=8'h01 in the same cycle as a new change -> flag stays 1. Write FLG=8'h01 with no change -> irq=0.
- Non-PCINT build: read MSK_ADDR -> out_en=0; toggle any pin -> pcint_irq stays 0.
